// File: rtl/perf_mon_pkg.sv
// Shared types and counter-index constants for the performance event monitor.
package perf_mon_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StDump,
        StDone
    } perf_mon_state_e;

    // Default event-to-counter mapping; index 0 is always the cycle counter.
    localparam int unsigned IDX_CYCLES = 0;
    localparam int unsigned IDX_RETIRE = 1;
    localparam int unsigned IDX_IREQ   = 2;
    localparam int unsigned IDX_IHIT   = 3;
    localparam int unsigned IDX_DREQ   = 4;
    localparam int unsigned IDX_DHIT   = 5;

endpackage

// File: rtl/perf_event_monitor_if.sv
// Valid/ready readout channel carrying one counter (index, value, last flag) per beat.
interface perf_event_monitor_if #(
    parameter int unsigned NUM_EVENTS = 5,
    parameter int unsigned CNT_W      = 32
);
    localparam int unsigned IDX_W = $clog2(NUM_EVENTS + 1);

    logic             dump_valid;
    logic             dump_ready;
    logic [IDX_W-1:0] dump_idx;
    logic [CNT_W-1:0] dump_data;
    logic             dump_last;

    modport master (
        output dump_valid,
        output dump_idx,
        output dump_data,
        output dump_last,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_idx,
        input  dump_data,
        input  dump_last,
        output dump_ready
    );

endinterface

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with a synchronous clear and a sticky overflow flag.
module perf_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic [CNT_W-1:0] cntQ, cntD;
    logic             ovfQ, ovfD;

    always_comb begin
        cntD = cntQ;
        ovfD = ovfQ;
        if (clr) begin
            cntD = '0;
            ovfD = 1'b0;
        end else if (inc) begin
            // At all-ones the value holds and only the flag records the lost increment.
            if (&cntQ) begin
                ovfD = 1'b1;
            end else begin
                cntD = cntQ + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntQ <= '0;
            ovfQ <= 1'b0;
        end else begin
            cntQ <= cntD;
            ovfQ <= ovfD;
        end
    end

    assign cnt = cntQ;
    assign ovf = ovfQ;

endmodule

// File: rtl/perf_event_monitor.sv
// Counts cycles and event strobes between start and halt, then streams all counters out.
module perf_event_monitor
    import perf_mon_pkg::*;
#(
    parameter int unsigned NUM_EVENTS = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NUM_EVENTS-1:0] events,
    input  logic                  halt,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_EVENTS:0]   ovf,
    perf_event_monitor_if.master  dump
);

    localparam int unsigned NUM_CNT = NUM_EVENTS + 1;
    localparam int unsigned IDX_W   = $clog2(NUM_CNT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EVENTS);

    perf_mon_state_e  stateQ, stateD;
    logic [IDX_W-1:0] idxQ, idxD;
    logic             clr;
    logic             countEn;
    logic [NUM_EVENTS:0] incVec;
    logic [CNT_W-1:0] cntArr [NUM_CNT];

    // Bit 0 is the cycle counter, which counts whenever counting is enabled.
    assign incVec = {events, 1'b1} & {NUM_CNT{countEn}};

    for (genvar g = 0; g < NUM_CNT; g++) begin : genCnt
        perf_sat_counter #(
            .CNT_W(CNT_W)
        ) uCnt (
            .clk  (clk),
            .rst_n(rst_n),
            .clr  (clr),
            .inc  (incVec[g]),
            .cnt  (cntArr[g]),
            .ovf  (ovf[g])
        );
    end

    always_comb begin
        stateD  = stateQ;
        idxD    = idxQ;
        clr     = 1'b0;
        countEn = 1'b0;
        unique case (stateQ)
            StIdle, StDone: begin
                if (start) begin
                    clr    = 1'b1;
                    stateD = StCount;
                end
            end
            StCount: begin
                // halt takes priority; the halt cycle itself is still counted.
                if (halt) begin
                    countEn = 1'b1;
                    stateD  = StDump;
                    idxD    = '0;
                end else if (start) begin
                    clr = 1'b1;
                end else begin
                    countEn = 1'b1;
                end
            end
            StDump: begin
                if (dump.dump_ready) begin
                    if (idxQ == LAST_IDX) begin
                        stateD = StDone;
                        idxD   = '0;
                    end else begin
                        idxD = idxQ + IDX_W'(1);
                    end
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= StIdle;
            idxQ   <= '0;
        end else begin
            stateQ <= stateD;
            idxQ   <= idxD;
        end
    end

    assign busy = (stateQ == StCount);
    assign done = (stateQ == StDone);

    // Counters are frozen during the dump, so the muxed value is stable under backpressure.
    assign dump.dump_valid = (stateQ == StDump);
    assign dump.dump_idx   = idxQ;
    assign dump.dump_data  = (stateQ == StDump) ? cntArr[idxQ] : '0;
    assign dump.dump_last  = (stateQ == StDump) && (idxQ == LAST_IDX);

endmodule

// File: tb/tb_perf_event_monitor.sv
// Directed bench for perf_event_monitor: default, narrow-counter and single-event instances.
module tb_perf_event_monitor;
    import perf_mon_pkg::*;

    typedef struct {
        int          idx;
        logic [63:0] data;
        bit          last;
    } ent_t;

    logic clk;
    logic rst_n;
    logic ready;
    int   nTests = 0;
    int   nFail  = 0;
    int   sel    = 0;
    ent_t sbQ[$];

    logic       start0, halt0, busy0, done0;
    logic [4:0] ev0;
    logic [5:0] ovf0;
    logic       start1, halt1, busy1, done1;
    logic [4:0] ev1;
    logic [5:0] ovf1;
    logic       start2, halt2, busy2, done2;
    logic [0:0] ev2;
    logic [1:0] ovf2;

    logic        oValid, oLast;
    logic [31:0] oIdx;
    logic [63:0] oData;

    perf_event_monitor_if #(.NUM_EVENTS(5), .CNT_W(32)) if0 ();
    perf_event_monitor_if #(.NUM_EVENTS(5), .CNT_W(4))  if1 ();
    perf_event_monitor_if #(.NUM_EVENTS(1), .CNT_W(8))  if2 ();

    assign if0.dump_ready = ready;
    assign if1.dump_ready = ready;
    assign if2.dump_ready = ready;

    perf_event_monitor #(.NUM_EVENTS(5), .CNT_W(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .events(ev0), .halt(halt0),
        .busy(busy0), .done(done0), .ovf(ovf0), .dump(if0.master)
    );
    perf_event_monitor #(.NUM_EVENTS(5), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .events(ev1), .halt(halt1),
        .busy(busy1), .done(done1), .ovf(ovf1), .dump(if1.master)
    );
    perf_event_monitor #(.NUM_EVENTS(1), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .events(ev2), .halt(halt2),
        .busy(busy2), .done(done2), .ovf(ovf2), .dump(if2.master)
    );

    always_comb begin
        oValid = 1'b0;
        oIdx   = '0;
        oData  = '0;
        oLast  = 1'b0;
        case (sel)
            1: begin
                oValid = if1.dump_valid;
                oIdx   = 32'(if1.dump_idx);
                oData  = 64'(if1.dump_data);
                oLast  = if1.dump_last;
            end
            2: begin
                oValid = if2.dump_valid;
                oIdx   = 32'(if2.dump_idx);
                oData  = 64'(if2.dump_data);
                oLast  = if2.dump_last;
            end
            default: begin
                oValid = if0.dump_valid;
                oIdx   = 32'(if0.dump_idx);
                oData  = 64'(if0.dump_data);
                oLast  = if0.dump_last;
            end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int idx, input logic [63:0] data, input bit last);
        ent_t e;
        e.idx  = idx;
        e.data = data;
        e.last = last;
        sbQ.push_back(e);
    endtask

    // Drains the selected DUT against the scoreboard; ready toggles 0/1 when requested.
    task automatic drain(input int s, input bit toggle, input int expCycles);
        int   cycles = 0;
        ent_t e;
        sel = s;
        while (sbQ.size() > 0 && cycles < 64) begin
            ready = toggle ? (cycles % 2 == 1) : 1'b1;
            #0;
            check("dump_valid", 64'(oValid), 64'd1);
            e = sbQ[0];
            check($sformatf("dump_idx@%0d", e.idx), 64'(oIdx), 64'(e.idx));
            check($sformatf("dump_data@%0d", e.idx), oData, e.data);
            check($sformatf("dump_last@%0d", e.idx), 64'(oLast), 64'(e.last));
            if (oValid && ready) void'(sbQ.pop_front());
            step();
            cycles++;
        end
        check("dump_cycles", 64'(cycles), 64'(expCycles));
        sbQ.delete();
        ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ready = 1'b0;
        start0 = 0; halt0 = 0; ev0 = '0;
        start1 = 0; halt1 = 0; ev1 = '0;
        start2 = 0; halt2 = 0; ev2 = '0;
        step();
        step();
        rst_n = 1'b1;
        step();

        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_done", 64'(done0), 64'd0);
        check("rst_valid", 64'(oValid), 64'd0);
        check("rst_idx", 64'(oIdx), 64'd0);
        check("rst_data", oData, 64'd0);
        check("rst_last", 64'(oLast), 64'd0);
        check("rst_ovf", 64'(ovf0), 64'd0);

        // halt in IDLE is ignored
        halt0 = 1;
        step();
        halt0 = 0;
        check("idle_halt_busy", 64'(busy0), 64'd0);
        check("idle_halt_valid", 64'(oValid), 64'd0);

        // Basic count
        start0 = 1;
        step();
        start0 = 0;
        check("basic_busy", 64'(busy0), 64'd1);
        for (int i = 0; i < 10; i++) begin
            ev0   = (i < 3) ? 5'b00101 : 5'b00001;
            halt0 = (i == 9);
            step();
        end
        ev0 = '0;
        halt0 = 0;
        push(IDX_CYCLES, 10, 0);
        push(IDX_RETIRE, 10, 0);
        push(IDX_IREQ, 0, 0);
        push(IDX_IHIT, 3, 0);
        push(IDX_DREQ, 0, 0);
        push(IDX_DHIT, 0, 1);
        drain(0, 0, 6);
        check("basic_done", 64'(done0), 64'd1);
        ev0 = 5'h1f;
        step();
        step();
        ev0 = '0;
        check("done_hold", 64'(done0), 64'd1);
        check("done_no_valid", 64'(oValid), 64'd0);

        // Backpressure, starting again from DONE
        start0 = 1;
        step();
        start0 = 0;
        for (int i = 0; i < 4; i++) begin
            ev0   = 5'b10010;
            halt0 = (i == 3);
            step();
        end
        ev0 = '0;
        halt0 = 0;
        push(0, 4, 0);
        push(1, 0, 0);
        push(2, 4, 0);
        push(3, 0, 0);
        push(4, 0, 0);
        push(5, 4, 1);
        drain(0, 1, 12);
        check("bp_done", 64'(done0), 64'd1);

        // Restart mid-run, then start+halt together
        start0 = 1;
        step();
        start0 = 0;
        for (int i = 0; i < 5; i++) begin
            ev0 = 5'h1f;
            step();
        end
        start0 = 1;
        step();
        start0 = 0;
        for (int i = 0; i < 3; i++) begin
            ev0    = 5'b00011;
            halt0  = (i == 2);
            start0 = (i == 2);
            step();
        end
        ev0 = '0;
        halt0 = 0;
        start0 = 0;
        check("rs_not_busy", 64'(busy0), 64'd0);
        check("rs_dump", 64'(oValid), 64'd1);
        push(0, 3, 0);
        push(1, 3, 0);
        push(2, 3, 0);
        push(3, 0, 0);
        push(4, 0, 0);
        push(5, 0, 1);
        drain(0, 0, 6);

        // Reset during idx2 of a dump
        start0 = 1;
        step();
        start0 = 0;
        ev0 = 5'b00001;
        step();
        halt0 = 1;
        step();
        ev0 = '0;
        halt0 = 0;
        ready = 1;
        step();
        step();
        check("mid_idx", 64'(oIdx), 64'd2);
        check("mid_valid", 64'(oValid), 64'd1);
        rst_n = 0;
        #1;
        ready = 0;
        check("mr_valid", 64'(oValid), 64'd0);
        check("mr_idx", 64'(oIdx), 64'd0);
        check("mr_data", oData, 64'd0);
        check("mr_last", 64'(oLast), 64'd0);
        check("mr_busy", 64'(busy0), 64'd0);
        check("mr_done", 64'(done0), 64'd0);
        step();
        rst_n = 1;
        step();
        halt0 = 1;
        step();
        halt0 = 0;
        check("mr_halt_busy", 64'(busy0), 64'd0);
        check("mr_halt_valid", 64'(oValid), 64'd0);
        check("mr_halt_done", 64'(done0), 64'd0);

        // Saturation on the 4-bit instance
        sel = 1;
        start1 = 1;
        step();
        start1 = 0;
        for (int i = 0; i < 20; i++) begin
            ev1   = 5'b00001;
            halt1 = (i == 19);
            step();
        end
        ev1 = '0;
        halt1 = 0;
        check("sat_ovf", 64'(ovf1), 64'b000011);
        push(0, 15, 0);
        push(1, 15, 0);
        push(2, 0, 0);
        push(3, 0, 0);
        push(4, 0, 0);
        push(5, 0, 1);
        drain(1, 0, 6);
        start1 = 1;
        step();
        start1 = 0;
        check("sat_ovf_clr", 64'(ovf1), 64'd0);

        // Single-event, 8-bit instance
        start2 = 1;
        step();
        start2 = 0;
        for (int i = 0; i < 3; i++) begin
            ev2   = (i != 1) ? 1'b1 : 1'b0;
            halt2 = (i == 2);
            step();
        end
        ev2 = '0;
        halt2 = 0;
        push(0, 3, 0);
        push(1, 2, 1);
        drain(2, 0, 2);
        check("small_done", 64'(done2), 64'd1);
        check("small_ovf", 64'(ovf2), 64'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/perf_event_monitor.md
# perf_event_monitor

Synthesizable, parametrised performance monitor for the pipelined processor and its cache hierarchy. Counts cycles plus `NUM_EVENTS` single-bit event strobes (retired instruction, I-cache request/hit, D-cache request/hit, …) between a `start` pulse and `halt`, then streams every counter out over a valid/ready port. It sits beside the processor core and generalises the bench-side statistics counters into hardware, adding configurable width and channel count, saturation with overflow flags, and handshaked readout.

## Interface
- `NUM_EVENTS`, 5: number of event channels; event `i` maps to counter index `i+1`.
- `CNT_W`, 32: width of every counter, including the cycle counter.
- `IDX_W`, `$clog2(NUM_EVENTS+1)`: derived width of the readout index; not overridden.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that clears all counters and begins counting.
- `events` input `NUM_EVENTS`: per-cycle event strobes, sampled each cycle.
- `halt` input 1: end-of-run strobe.
- `busy` output 1: high in COUNT.
- `done` output 1: high in DONE.
- `ovf` output `NUM_EVENTS+1`: sticky saturation flags; bit 0 is the cycle counter.
- `dump_valid` output 1: readout entry valid.
- `dump_ready` input 1: consumer accepts the entry.
- `dump_idx` output `IDX_W`: counter index, 0 is cycles.
- `dump_data` output `CNT_W`: counter value.
- `dump_last` output 1: marks index `NUM_EVENTS`.

## Operation
- States: IDLE (after reset), COUNT, DUMP, DONE.
- IDLE: counters hold. `start` clears all counters and `ovf`, then moves to COUNT. `halt` is ignored.
- COUNT: the cycle counter increments each cycle. Counter `i+1` increments when `events[i]` is 1. Each counter saturates at all-ones, and the attempt to increment past it sets its `ovf` bit (sticky).
- COUNT with `halt`: that cycle's events and cycle are still counted. Next state is DUMP with index 0.
- COUNT with `start` and no `halt`: counters and `ovf` clear. The cycle's events are not counted. State stays COUNT.
- COUNT with `start` and `halt` together: `halt` wins and `start` is ignored.
- DUMP:
  - `dump_valid` = 1, `dump_data` = counter[`dump_idx`].
  - On `dump_valid && dump_ready`, the index advances.
  - When the accepted entry has `dump_last`, the state moves to DONE.
  - `start` and `halt` are ignored.
  - Counters are frozen.
- DONE: `done` = 1. Counters hold and stay readable by a new dump only after a new run. `start` clears and enters COUNT.
- Width rule: all increments are `CNT_W`-bit unsigned with no wrap-around. Saturation is the only overflow behaviour.

## Timing
- Reset values: state IDLE, all counters 0, `ovf` 0, `busy` 0, `done` 0, `dump_valid` 0, `dump_idx` 0, `dump_data` 0, `dump_last` 0.
- Count latency: an event in cycle t is visible in the counter at t+1.
- `start` in cycle t: counting begins with the events of cycle t+1.
- The first dump entry is valid the cycle after `halt`.
- One entry per cycle under constant `dump_ready`. A full dump takes `NUM_EVENTS+1` cycles; `done` rises the cycle after the last handshake.
- `dump_idx`/`dump_data`/`dump_last` are registered and stable while `dump_valid && !dump_ready`.
- `rst_n` low in any state, including mid-dump, immediately forces the reset values. No partial entry is retained.

## Structure
- Package `perf_mon_pkg`:
  - state enum (IDLE, COUNT, DUMP, DONE);
  - index constants `IDX_CYCLES`=0, `IDX_RETIRE`=1, `IDX_IREQ`=2, `IDX_IHIT`=3, `IDX_DREQ`=4, `IDX_DHIT`=5 for the default mapping.
- Sub-module `perf_sat_counter`: one `CNT_W` counter with inputs `clr` and `inc` and outputs `cnt` and sticky `ovf`. It is instantiated `NUM_EVENTS+1` times through a generate loop.
- The top level holds the FSM, the readout index, and the output mux/registers.

## Test plan
- Basic count: `start`, then 10 cycles with `events`=5'b00001 every cycle and `events[2]` on 3 of them, then `halt` on cycle 10. Required dump, with `dump_ready`=1: idx0=10, idx1=10, idx3=3, all others 0, `dump_last` only on idx5, `done` the following cycle.
- Saturation: `CNT_W`=4, event 0 held for 20 cycles. Required: counter1=15 and `ovf[1]`=1; cycle counter=15 with `ovf[0]`=1; other `ovf` bits 0.
- Backpressure: in DUMP, `dump_ready` toggles 0/1 each cycle. Required: each index appears exactly once, held stable while not ready; 6 entries take 12 cycles.
- Restart: `start` again at cycle 5 of a run with events active. Required: counters reflect only cycles after the second `start`, and `ovf` is cleared. `start` and `halt` in the same cycle → enters DUMP.
- Reset mid-dump: drop `rst_n` during idx2. Required: immediately `dump_valid`=0 and all outputs at reset values; after release, state IDLE and `halt` is ignored.
- Parametrisation: `NUM_EVENTS`=1, `CNT_W`=8. Required: 2-entry dump, `IDX_W`=1, `dump_last` on idx1.
